dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU's MEM stage and the external data memory.
- Serves word loads and stores from the MEM stage.
- On a miss, raises a stall to the pipeline, writes back a dirty victim, refills the 256-bit line, then completes the access.

Parameters:
- NUM_LINES, 32, number of cache lines; power of two; index width IDX_W = log2(NUM_LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5, word select = addr[4:2].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- cpu_req_i  in  1  MEM-stage access valid (load or store).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address, word aligned.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data, valid when cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freezes the whole pipeline while high.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  1 = line write-back, 0 = line read.
- mem_addr_o  out  32  line-aligned address (low 5 bits zero).
- mem_wdata_o  out  256  victim line data.
- mem_rdata_i  in  256  refill data, valid with mem_ack_i.
- mem_ack_i  in  1  single-cycle completion pulse.

Interface (already decided):
- One clock, clk_i.
- Reset rst_i is synchronous and active-high.

Behaviour:
- Address split: tag = addr[31:5+IDX_W], index = addr[4+IDX_W:5], word = addr[4:2].
- Reset:
  - All valid and dirty bits cleared; state IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0, cpu_stall_o=0.
  - Data and tag arrays are not cleared.
- Hit = cpu_req_i & valid[index] & tag match.
- IDLE:
  - Load hit: cpu_rdata_o driven combinationally from the array, zero-cycle latency, no stall.
  - Store hit: word written at the clock edge, dirty set, no stall.
  - Miss: cpu_stall_o asserted combinationally in the same cycle. Next state is WRITEBACK if the victim is valid&dirty, else ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: line <= mem_rdata_i, tag updated, valid=1, dirty=0; go to COMPLETE.
- COMPLETE:
  - One cycle; the access now hits. The load returns data, or the store merges the word and sets dirty.
  - cpu_stall_o=0 this cycle; next state IDLE.
- cpu_stall_o=1 in WRITEBACK and ALLOCATE, and in IDLE on a miss.
- mem_req_o is registered. It rises the cycle after the miss is detected and drops the cycle after ack.
- Address, data and control are held stable by the stalled pipeline. The block does not latch cpu_* inputs, except the victim tag and index, which are captured on miss entry.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- cpu_req_i=0: no array update, cpu_stall_o=0, cpu_rdata_o=0.
- Reset mid-miss: aborts immediately. mem_req_o drops at that edge; any partial line is discarded (valid cleared).
- Ack arriving in the same cycle as rst_i: reset wins.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each counter increments once per completed access: hits in IDLE, misses on entry to the miss path.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package dcache_pkg:
  - State enum {IDLE, WRITEBACK, ALLOCATE, COMPLETE}.
  - Constants OFFSET_W=5 and WORD_SEL_W=3.
  - Function deriving TAG_W from NUM_LINES.
- Sub-module dcache_sram: tag/valid/dirty arrays plus data array, with one combinational read port and one synchronous write port (full-line or single-word write with dirty update). The FSM stays in dcache_ctrl.

Test Plan:
- Reset, then load addr 0x0000_0040 with memory line word0=0x1234_5678: stall for 1 + mem latency + 1 cycles, one read request to 0x40, then cpu_rdata_o=0x1234_5678. A repeat load hits with no stall.
- Store 0xDEAD_BEEF to 0x44 after the fill: no stall, no mem_req_o. A load from 0x44 returns 0xDEAD_BEEF.
- Load 0x0000_0440 (same index, different tag), with line 0x40 dirty: write-back request to 0x40 with word1=0xDEAD_BEEF, then a read to 0x440, then data returned.
- Load miss on a clean victim: no write-back; exactly one mem_req_o with mem_we_o=0.
- Assert rst_i while in ALLOCATE before ack: the next cycle shows mem_req_o=0 and cpu_stall_o=0, and a reload of the same address misses.
- With DCACHE_STATS_EN defined, run 3 hits and 2 misses: hit_cnt_o=3, miss_cnt_o=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: controller state encoding, address field widths and the tag-width helper
// shared by the data cache controller and its storage arrays.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      COMPLETE
   } dcacheStateT;

   localparam int OFFSET_W   = 5;
   localparam int WORD_SEL_W = 3;

   // The tag is whatever is left of a 32-bit address after the index and line offset.
   function automatic int tagWidth(input int numLines);
      return 32 - OFFSET_W - $clog2(numLines);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty and line storage for the direct-mapped data cache, with one
// combinational read port and one synchronous write port (whole-line refill or single-word store).
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int TAG_W     = tagWidth(NUM_LINES)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [IDX_W-1:0]      rdIndex,
   output logic                  rdValid,
   output logic                  rdDirty,
   output logic [TAG_W-1:0]      rdTag,
   output logic [LINE_BITS-1:0]  rdLine,
   input  logic                  lineWe,
   input  logic                  wordWe,
   input  logic [IDX_W-1:0]      wrIndex,
   input  logic [TAG_W-1:0]      wrTag,
   input  logic [LINE_BITS-1:0]  wrLine,
   input  logic [WORD_SEL_W-1:0] wrWordSel,
   input  logic [31:0]           wrWord
);

   logic [LINE_BITS-1:0] dataArr [NUM_LINES];
   logic [TAG_W-1:0]     tagArr  [NUM_LINES];
   logic [NUM_LINES-1:0] validBits;
   logic [NUM_LINES-1:0] dirtyBits;

   assign rdValid = validBits[rdIndex];
   assign rdDirty = dirtyBits[rdIndex];
   assign rdTag   = tagArr[rdIndex];
   assign rdLine  = dataArr[rdIndex];

   // Status bits are the only storage cleared by reset; a refill leaves the line clean,
   // a word store marks it dirty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         validBits <= '0;
         dirtyBits <= '0;
      end else if (lineWe) begin
         validBits[wrIndex] <= 1'b1;
         dirtyBits[wrIndex] <= 1'b0;
      end else if (wordWe) begin
         dirtyBits[wrIndex] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset so they can map onto plain RAM; stale contents are
   // harmless because the valid bits gate every hit.
   always_ff @(posedge clk_i) begin
      if (lineWe) begin
         dataArr[wrIndex] <= wrLine;
         tagArr[wrIndex]  <= wrTag;
      end else if (wordWe) begin
         dataArr[wrIndex][int'(wrWordSel)*32 +: 32] <= wrWord;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache controller.
// Defining DCACHE_STATS_EN adds hit_cnt_o/miss_cnt_o access counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`endif
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = tagWidth(NUM_LINES);

   dcacheStateT state, nextState;

   logic [TAG_W-1:0]      reqTag;
   logic [IDX_W-1:0]      reqIdx;
   logic [WORD_SEL_W-1:0] reqWord;
   logic                  unusedAddrBits;

   logic                  rdValid, rdDirty;
   logic [TAG_W-1:0]      rdTag;
   logic [LINE_BITS-1:0]  rdLine;
   logic [31:0]           lineWord;
   logic                  hit;

   logic                  lineWe, wordWe;
   logic [IDX_W-1:0]      wrIndex;

   logic [TAG_W-1:0]      victimTag;
   logic [IDX_W-1:0]      victimIdx;
   logic                  captureVictim;

   logic                  memReqQ, memReqD;
   logic                  memWeQ, memWeD;
   logic [31:0]           memAddrQ, memAddrD;
   logic [LINE_BITS-1:0]  memWdataQ, memWdataD;

   logic                  stall;
   logic [31:0]           rdataD;
   logic                  countHit, countMiss;

   assign reqTag         = cpu_addr_i[31:OFFSET_W+IDX_W];
   assign reqIdx         = cpu_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
   assign reqWord        = cpu_addr_i[OFFSET_W-1:2];
   assign unusedAddrBits = ^cpu_addr_i[1:0];

   assign lineWord = rdLine[int'(reqWord)*32 +: 32];
   assign hit      = cpu_req_i && rdValid && (rdTag == reqTag);
   assign wrIndex  = lineWe ? victimIdx : reqIdx;

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .LINE_BITS (LINE_BITS),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rdIndex   (reqIdx),
      .rdValid   (rdValid),
      .rdDirty   (rdDirty),
      .rdTag     (rdTag),
      .rdLine    (rdLine),
      .lineWe    (lineWe),
      .wordWe    (wordWe),
      .wrIndex   (wrIndex),
      .wrTag     (reqTag),
      .wrLine    (mem_rdata_i),
      .wrWordSel (reqWord),
      .wrWord    (cpu_wdata_i)
   );

   // Next-state and memory-request logic. The memory-side outputs are computed here one
   // cycle early and registered, so mem_req_o rises the cycle after a miss and drops the
   // cycle after the refill ack; the CPU-side stall and read data stay combinational.
   always_comb begin
      nextState     = state;
      memReqD       = memReqQ;
      memWeD        = memWeQ;
      memAddrD      = memAddrQ;
      memWdataD     = memWdataQ;
      captureVictim = 1'b0;
      lineWe        = 1'b0;
      wordWe        = 1'b0;
      stall         = 1'b0;
      rdataD        = '0;
      countHit      = 1'b0;
      countMiss     = 1'b0;

      case (state)
         IDLE: begin
            if (hit) begin
               rdataD   = lineWord;
               wordWe   = cpu_we_i;
               countHit = 1'b1;
            end else if (cpu_req_i) begin
               stall         = 1'b1;
               captureVictim = 1'b1;
               countMiss     = 1'b1;
               memReqD       = 1'b1;
               if (rdValid && rdDirty) begin
                  nextState = WRITEBACK;
                  memWeD    = 1'b1;
                  memAddrD  = {rdTag, reqIdx, {OFFSET_W{1'b0}}};
                  memWdataD = rdLine;
               end else begin
                  nextState = ALLOCATE;
                  memWeD    = 1'b0;
                  memAddrD  = {reqTag, reqIdx, {OFFSET_W{1'b0}}};
               end
            end
         end
         WRITEBACK: begin
            stall    = 1'b1;
            memAddrD = {victimTag, victimIdx, {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               nextState = ALLOCATE;
               memWeD    = 1'b0;
               memAddrD  = {reqTag, victimIdx, {OFFSET_W{1'b0}}};
            end
         end
         ALLOCATE: begin
            stall = 1'b1;
            if (mem_ack_i) begin
               lineWe    = 1'b1;
               nextState = COMPLETE;
               memReqD   = 1'b0;
               memWeD    = 1'b0;
            end
         end
         COMPLETE: begin
            nextState = IDLE;
            if (cpu_req_i) begin
               rdataD = lineWord;
               wordWe = cpu_we_i;
            end
         end
         default: nextState = IDLE;
      endcase

      if (rst_i) begin
         stall  = 1'b0;
         rdataD = '0;
         lineWe = 1'b0;
         wordWe = 1'b0;
      end
   end

   assign cpu_stall_o = stall;
   assign cpu_rdata_o = rdataD;
   assign mem_req_o   = memReqQ;
   assign mem_we_o    = memWeQ;
   assign mem_addr_o  = memAddrQ;
   assign mem_wdata_o = memWdataQ;

   // State and registered memory interface; reset abandons any miss in flight at once.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         memReqQ   <= 1'b0;
         memWeQ    <= 1'b0;
         memAddrQ  <= '0;
         memWdataQ <= '0;
         victimTag <= '0;
         victimIdx <= '0;
      end else begin
         state     <= nextState;
         memReqQ   <= memReqD;
         memWeQ    <= memWeD;
         memAddrQ  <= memAddrD;
         memWdataQ <= memWdataD;
         if (captureVictim) begin
            victimTag <= rdTag;
            victimIdx <= reqIdx;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hitCnt, missCnt;

   // A hit counts when it completes in IDLE; a miss counts once, on entry to the miss path.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hitCnt  <= '0;
         missCnt <= '0;
      end else begin
         if (countHit)  hitCnt  <= hitCnt + 32'd1;
         if (countMiss) missCnt <= missCnt + 32'd1;
      end
   end

   assign hit_cnt_o  = hitCnt;
   assign miss_cnt_o = missCnt;
`else
   logic unusedCounts;
   assign unusedCounts = countHit ^ countMiss;
`endif

endmodule
